// File: rtl/vga_timing_checker.sv
// Sink-side monitor for a VGA HS/VS/blank stream: locks onto the frame, recovers
// row/col and raises sticky flags on timing or blanking violations once locked.
module vga_timing_checker #(
  parameter int unsigned H_PULSE = 192,
  parameter int unsigned H_BP    = 96,
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned H_FP    = 32,
  parameter int unsigned V_PULSE = 2,
  parameter int unsigned V_BP    = 29,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank,
  input  logic        err_clear,
  output logic        locked,
  output logic        rec_valid,
  output logic [8:0]  rec_row,
  output logic [9:0]  rec_col,
  output logic        hs_err,
  output logic        vs_err,
  output logic        blank_err,
  output logic [15:0] frame_count
);
  localparam int unsigned LINE  = H_PULSE + H_BP + H_DISP + H_FP;
  localparam int unsigned FRAME = (V_PULSE + V_BP + V_DISP + V_FP) * LINE;

  localparam logic [11:0] LP_LINE  = 12'(LINE);
  localparam logic [11:0] LP_LINE1 = 12'(LINE + 1);
  localparam logic [11:0] LP_HPUL  = 12'(H_PULSE);
  localparam logic [10:0] LP_X0    = 11'(H_PULSE + H_BP);
  localparam logic [10:0] LP_X1    = 11'(H_PULSE + H_BP + H_DISP - 1);
  localparam logic [9:0]  LP_Y0    = 10'(V_PULSE + V_BP);
  localparam logic [9:0]  LP_Y1    = 10'(V_PULSE + V_BP + V_DISP - 1);
  localparam logic [20:0] LP_VREL  = 21'(V_PULSE * LINE);
  localparam logic [20:0] LP_FRAME = 21'(FRAME);
  localparam logic [20:0] LP_FRM1  = 21'(FRAME + 1);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic        r_hs_d, r_vs_d;
  logic [10:0] r_p;
  logic [9:0]  r_l;
  logic [19:0] r_f;
  logic [1:0]  r_state;
  logic        r_locked, r_rec_valid, r_hs_err, r_vs_err, r_blank_err;
  logic [8:0]  r_rec_row;
  logic [9:0]  r_rec_col;
  logic [15:0] r_frame_count;

  logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic [11:0] w_p_inc;
  logic [20:0] w_f_inc;
  logic [10:0] w_p;
  logic [9:0]  w_l;
  logic [19:0] w_f;
  logic        w_h_viol, w_v_viol, w_disp, w_valid;
  logic        w_in_lock, w_blank_mis, w_fc_inc;
  logic [1:0]  w_nxt;

  assign w_hs_fall = r_hs_d & ~HS;
  assign w_hs_rise = ~r_hs_d & HS;
  assign w_vs_fall = r_vs_d & ~VS;
  assign w_vs_rise = ~r_vs_d & VS;

  // Unsaturated "what the count would be" values double as the measured periods.
  assign w_p_inc = {1'b0, r_p} + 12'd1;
  assign w_f_inc = {1'b0, r_f} + 21'd1;

  assign w_p = w_hs_fall ? '0 : ((&r_p) ? r_p : w_p_inc[10:0]);
  assign w_f = w_vs_fall ? '0 : ((&r_f) ? r_f : w_f_inc[19:0]);
  assign w_l = w_vs_fall ? '0 :
               ((w_hs_fall && !(&r_l)) ? r_l + 10'd1 : r_l);

  assign w_h_viol = (w_hs_fall && (w_p_inc != LP_LINE)) ||
                    (w_hs_rise && ({1'b0, w_p} != LP_HPUL)) ||
                    (!w_hs_fall && ({1'b0, w_p} == LP_LINE1));

  assign w_v_viol = (w_vs_fall && !w_hs_fall) ||
                    (w_vs_rise && ({1'b0, w_f} != LP_VREL)) ||
                    (w_vs_fall && (w_f_inc != LP_FRAME)) ||
                    (!w_vs_fall && ({1'b0, w_f} == LP_FRM1));

  assign w_disp = (w_l >= LP_Y0) && (w_l <= LP_Y1) &&
                  (w_p >= LP_X0) && (w_p <= LP_X1);

  assign w_in_lock   = (r_state == S_LOCKED);
  assign w_blank_mis = w_in_lock && (blank == w_disp);
  // A VS fall is counted when it either confirms the lock or keeps it.
  assign w_fc_inc    = w_vs_fall && !w_h_viol && !w_v_viol && (r_state != S_SEARCH);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_SEARCH:  if (w_vs_fall && w_hs_fall) w_nxt = S_ACQUIRE;
      S_ACQUIRE: if (w_h_viol || w_v_viol) w_nxt = S_SEARCH;
                 else if (w_vs_fall)      w_nxt = S_LOCKED;
      S_LOCKED:  if (w_h_viol || w_v_viol) w_nxt = S_SEARCH;
      default:   w_nxt = S_SEARCH;
    endcase
  end

  assign w_valid = (w_nxt == S_LOCKED) && w_disp;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hs_d        <= 1'b0;
      r_vs_d        <= 1'b0;
      r_p           <= '0;
      r_l           <= '0;
      r_f           <= '0;
      r_state       <= S_SEARCH;
      r_locked      <= 1'b0;
      r_rec_valid   <= 1'b0;
      r_rec_row     <= '0;
      r_rec_col     <= '0;
      r_hs_err      <= 1'b0;
      r_vs_err      <= 1'b0;
      r_blank_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hs_d        <= HS;
      r_vs_d        <= VS;
      r_p           <= w_p;
      r_l           <= w_l;
      r_f           <= w_f;
      r_state       <= w_nxt;
      r_locked      <= (w_nxt == S_LOCKED);
      r_rec_valid   <= w_valid;
      r_rec_row     <= w_valid ? 9'(w_l - LP_Y0) : '0;
      r_rec_col     <= w_valid ? 10'((w_p - LP_X0) >> 1) : '0;
      // Setting beats a simultaneous clear.
      r_hs_err      <= (w_in_lock && w_h_viol) || (r_hs_err && !err_clear);
      r_vs_err      <= (w_in_lock && w_v_viol) || (r_vs_err && !err_clear);
      r_blank_err   <= w_blank_mis || (r_blank_err && !err_clear);
      if (w_fc_inc) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign locked      = r_locked;
  assign rec_valid   = r_rec_valid;
  assign rec_row     = r_rec_row;
  assign rec_col     = r_rec_col;
  assign hs_err      = r_hs_err;
  assign vs_err      = r_vs_err;
  assign blank_err   = r_blank_err;
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker: small-geometry sync generator with injected faults,
// checked every cycle against an event-timestamp reference model.
module tb_vga_timing_checker;
  localparam int HP = 8, HB = 4, HD = 16, HF = 4;
  localparam int VP = 2, VB = 3, VD = 4, VF = 2;
  localparam int LINE = HP + HB + HD + HF;
  localparam int LINES = VP + VB + VD + VF;
  localparam int FRAME = LINES * LINE;
  localparam int X0 = HP + HB, X1 = HP + HB + HD - 1;
  localparam int Y0 = VP + VB, Y1 = VP + VB + VD - 1;

  logic CLOCK_50 = 1'b0, reset = 1'b0, HS = 1'b1, VS = 1'b1, blank = 1'b1, err_clear = 1'b0;
  logic locked, rec_valid, hs_err, vs_err, blank_err;
  logic [8:0] rec_row;
  logic [9:0] rec_col;
  logic [15:0] frame_count;

  vga_timing_checker #(.H_PULSE(HP), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
                       .V_PULSE(VP), .V_BP(VB), .V_DISP(VD), .V_FP(VF)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .HS(HS), .VS(VS), .blank(blank),
    .err_clear(err_clear), .locked(locked), .rec_valid(rec_valid), .rec_row(rec_row),
    .rec_col(rec_col), .hs_err(hs_err), .vs_err(vs_err), .blank_err(blank_err),
    .frame_count(frame_count));

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_err = 0;
  // generator position and fault knobs
  int gx = LINE - 6, gy = LINES - 1;
  int short_y = -1, force_y = -1;
  bit long_vs = 0, flip_blank = 0, clr_now = 0, rst_now = 0, rnd = 0;
  // reference model: timestamps of the last falls plus the line count since VS
  int t = 0, ths = 0, tvs = 0, nl = 0, st = 0, fc = 0;
  bit prev_hs = 0, prev_vs = 0;
  bit e_locked = 0, e_valid = 0, e_hs = 0, e_vs = 0, e_bl = 0;
  int e_row = 0, e_col = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model(bit hs, bit vs, bit bl, bit clr, bit rst);
    bit hf, hr, vf, vr, hv, vv, disp, lk;
    int pper, fper, p, f;
    if (rst) begin
      prev_hs = 0; prev_vs = 0; ths = t; tvs = t; nl = 0; st = 0; fc = 0;
      e_locked = 0; e_valid = 0; e_row = 0; e_col = 0; e_hs = 0; e_vs = 0; e_bl = 0;
    end else begin
      hf = prev_hs && !hs; hr = !prev_hs && hs;
      vf = prev_vs && !vs; vr = !prev_vs && vs;
      pper = t - ths; fper = t - tvs;
      if (hf) ths = t;
      if (vf) tvs = t;
      p = (t - ths > 2047) ? 2047 : t - ths;
      f = (t - tvs > 1048575) ? 1048575 : t - tvs;
      if (vf) nl = 0; else if (hf && nl < 1023) nl++;
      hv = (hf && pper != LINE) || (hr && p != HP) || (!hf && p == LINE + 1);
      vv = (vf && !hf) || (vr && f != VP * LINE) || (vf && fper != FRAME) ||
           (!vf && f == FRAME + 1);
      disp = nl >= Y0 && nl <= Y1 && p >= X0 && p <= X1;
      lk = (st == 2);
      e_hs = (lk && hv) || (e_hs && !clr);
      e_vs = (lk && vv) || (e_vs && !clr);
      e_bl = (lk && bl == disp) || (e_bl && !clr);
      if (st == 0) begin
        if (vf && hf) st = 1;
      end else if (hv || vv) st = 0;
      else if (vf) begin st = 2; fc = (fc + 1) % 65536; end
      e_locked = (st == 2);
      e_valid = e_locked && disp;
      e_row = e_valid ? nl - Y0 : 0;
      e_col = e_valid ? (p - X0) / 2 : 0;
      prev_hs = hs; prev_vs = vs;
    end
    t++;
  endtask

  task automatic step();
    bit hs, vs, bl, clr;
    hs = gx >= ((gy == short_y) ? HP - 2 : HP);
    vs = gy >= (long_vs ? 3 : VP);
    bl = !(gy >= Y0 && gy <= Y1 && gx >= X0 && gx <= X1);
    if (gy == force_y) bl = 1;
    if (flip_blank) bl = !bl;
    clr = clr_now;
    if (rnd) begin
      if ($urandom_range(0, 199) == 0) hs = !hs;
      if ($urandom_range(0, 249) == 0) vs = !vs;
      if ($urandom_range(0, 49) == 0) bl = !bl;
      if ($urandom_range(0, 99) == 0) clr = 1;
    end
    HS = hs; VS = vs; blank = bl; err_clear = clr; reset = rst_now;
    @(posedge CLOCK_50);
    model(hs, vs, bl, clr, rst_now);
    #1;
    chk("locked", 32'(locked), 32'(e_locked));
    chk("rec_valid", 32'(rec_valid), 32'(e_valid));
    chk("rec_row", 32'(rec_row), e_row);
    chk("rec_col", 32'(rec_col), e_col);
    chk("hs_err", 32'(hs_err), 32'(e_hs));
    chk("vs_err", 32'(vs_err), 32'(e_vs));
    chk("blank_err", 32'(blank_err), 32'(e_bl));
    chk("frame_count", 32'(frame_count), fc);
    flip_blank = 0; clr_now = 0;
    if (++gx == LINE) begin
      gx = 0;
      if (++gy == LINES) begin gy = 0; short_y = -1; force_y = -1; long_vs = 0; end
    end
  endtask

  task automatic run_frames(int n);
    for (int i = 0; i < n * FRAME; i++) step();
  endtask

  task automatic to_frame_start();
    for (int i = 0; i < FRAME && !(gx == 0 && gy == 0); i++) step();
  endtask

  initial begin
    rst_now = 1;
    repeat (3) step();
    rst_now = 0;
    chk("reset_locked", 32'(locked), 0);
    to_frame_start();
    run_frames(3);
    chk("lock_after_2_falls", 32'(locked), 1);
    chk("lock_frame_count", 32'(frame_count), 2);
    // shortened HS pulse on a random line
    short_y = $urandom_range(1, LINES - 1);
    run_frames(1);
    chk("short_hs_err", 32'(hs_err), 1);
    chk("short_hs_unlock", 32'(locked), 0);
    run_frames(3);
    chk("relock_after_hs", 32'(locked), 1);
    chk("hs_err_sticky", 32'(hs_err), 1);
    // blank forced high on one display line, with a clear at frame start
    force_y = $urandom_range(Y0, Y1);
    clr_now = 1;
    run_frames(1);
    chk("blank_err_set", 32'(blank_err), 1);
    chk("blank_keeps_lock", 32'(locked), 1);
    chk("hs_err_cleared", 32'(hs_err), 0);
    // VS held low for 3 lines
    long_vs = 1;
    run_frames(1);
    chk("long_vs_err", 32'(vs_err), 1);
    chk("long_vs_unlock", 32'(locked), 0);
    run_frames(3);
    // clear coinciding with a new blank mismatch inside the display area
    for (int i = 0; i < FRAME && !(gy == Y0 && gx == X0 + 2); i++) step();
    flip_blank = 1; clr_now = 1;
    step();
    chk("clear_vs_set_wins_blank", 32'(blank_err), 1);
    chk("clear_vs_err", 32'(vs_err), 0);
    // reset in the middle of a locked frame
    repeat ($urandom_range(10, FRAME - 10)) step();
    rst_now = 1;
    step();
    rst_now = 0;
    chk("midreset_locked", 32'(locked), 0);
    chk("midreset_fc", 32'(frame_count), 0);
    chk("midreset_blank_err", 32'(blank_err), 0);
    to_frame_start();
    run_frames(3);
    chk("relock_after_reset", 32'(locked), 1);
    // random glitches on every input, then a clean stream to recover
    rnd = 1;
    run_frames(6);
    rnd = 0;
    run_frames(4);
    chk("relock_after_glitches", 32'(locked), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_checker.md
Name: vga_timing_checker

Overview:
- Sink-side monitor for the 640x480 VGA sync stream: consumes HS, VS and blank, clocked on CLOCK_50 (2 clocks per pixel).
- Locks onto the frame structure, recovers pixel row/col, and flags timing or blanking violations with sticky error bits.
- Used in the lab testbench and on-board self-check, placed alongside the VGA timing generator.

Parameters:
H_PULSE, 192, HS low width in CLOCK_50 cycles
H_BP, 96, horizontal back porch, cycles
H_DISP, 1280, horizontal display, cycles (640 px)
H_FP, 32, horizontal front porch, cycles; line period = sum = 1600
V_PULSE, 2, VS low width in lines
V_BP, 29, vertical back porch, lines
V_DISP, 480, vertical display, lines
V_FP, 10, vertical front porch, lines; frame = 521 lines = 833600 cycles

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
HS  in  1  horizontal sync, active low
VS  in  1  vertical sync, active low
blank  in  1  1 = outside display area
err_clear  in  1  clears sticky error flags
locked  out  1  1 = state LOCKED
rec_valid  out  1  locked and in expected display area
rec_row  out  9  recovered row 0..479 (0 when not rec_valid)
rec_col  out  10  recovered col 0..639 (0 when not rec_valid)
hs_err  out  1  sticky: HS width/period violation while LOCKED
vs_err  out  1  sticky: VS width/period/alignment violation while LOCKED
blank_err  out  1  sticky: blank mismatch while LOCKED
frame_count  out  16  VS falls counted in LOCKED, wraps at 65535->0

Behaviour:
- Reset: all outputs 0; state SEARCH; internal counters 0. Reset mid-frame behaves identically and re-locking restarts from SEARCH.
- Edge detection: registered previous HS/VS. A fall is the first cycle an input is sampled 0 after being sampled 1.
- Position p:
  - p = 0 on an HS-fall cycle, then increments each cycle; saturates at 2047.
  - Line index l = 0 on a VS-fall cycle, +1 on each subsequent HS fall; saturates at 1023.
  - Frame cycle counter f = 0 on a VS fall, +1 per cycle; 20-bit, saturating.
- HS check: HS must return high at exactly p = H_PULSE. The next HS fall must occur at exactly p = 1600. Failure = h-violation. Also a violation if p reaches 1601 with no fall.
- VS check, any of the following = v-violation:
  - VS fall not in the same cycle as an HS fall.
  - VS rise not at exactly f = V_PULSE*1600.
  - Next VS fall not at exactly f = 833600, or f reaching 833601 with no fall.
- Expected display: l in [V_PULSE+V_BP, 510] and p in [H_PULSE+H_BP, 1567]. Expected blank = NOT expected display. blank_err condition: blank != expected blank, evaluated only in LOCKED.
- FSM:
  - SEARCH: on an aligned VS fall -> ACQUIRE.
  - ACQUIRE: any h/v-violation -> SEARCH. Next aligned VS fall with no violation since entry -> LOCKED.
  - LOCKED: h-violation sets hs_err and goes to SEARCH; v-violation sets vs_err and goes to SEARCH. Blank mismatch sets blank_err only; lock is retained.
- Sticky flags: set only in LOCKED. err_clear clears them; a set in the same cycle as err_clear wins (flag = 1).
- Latency: every output is registered and reflects the inputs sampled in the previous cycle (1-cycle latency).
- rec_row = l - 31. rec_col = (p - 288) >> 1, so each col is held for 2 cycles. Both are 0 whenever rec_valid = 0.
- frame_count increments in the cycle after each VS fall taken in LOCKED, including the fall that enters LOCKED.

Test Plan:
- Clean generator stream for 3 frames after reset -> first VS fall enters ACQUIRE; second VS fall (833600 cycles later) gives locked = 1 one cycle later and frame_count = 1; all errors 0 throughout.
- Locked, line 31: at p = 288 -> next cycle rec_valid = 1, row 0, col 0. At p = 1567 -> col 639. At line 510, p = 1567 -> row 479. At p = 1568 -> rec_valid = 0.
- Locked, one HS pulse shortened to 190 cycles -> hs_err = 1, locked = 0 next cycle. Re-lock takes 2 further VS falls; hs_err stays 1 until err_clear.
- Locked, blank forced 1 during one display line -> blank_err = 1, locked stays 1, rec_valid continues to follow the timing.
- Locked, VS held low 3 lines -> vs_err = 1, locked = 0. err_clear asserted in the same cycle as a new blank mismatch -> blank_err stays 1.
- Reset asserted mid-frame while locked -> next cycle all outputs 0. Stream continues -> locked returns after 2 VS falls.
